mc_controller: RTL and testbench

Multicycle sequencing controller for the MIPS core's non-pipelined build variant. It shares one ALU and one unified instruction/data memory port across the fetch, decode, execute, memory and writeback phases. It drives every datapath enable and mux select from a Moore state machine and stretches memory phases with a ready handshake. It decodes the same instruction subset as the single-cycle/pipelined controller: R-type add/sub/and/or/slt, lw, sw, beq, addi and j.

---
 rtl/mc_controller_if.sv | 53 +++++
 rtl/mc_controller.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mc_controller_if                                            |
// | Purpose  : Control/status bundle between the multicycle MIPS sequencer |
// |            and its datapath plus unified memory port.                  |
// | Modports : master - the sequencer (drives strobes, selects, counters)  |
// |            slave  - the datapath/memory side (drives instruction       |
// |                     fields, ALU zero flag and memory ready)            |
// | Signals  : opcode_i, funct_i, zero_i, mem_ready_i (to sequencer)       |
// |            mem_req_o, memwrite_o, irwrite_o, pcen_o, regwrite_o,       |
// |            iord_o, memtoreg_o, regdst_o, alusrca_o, alusrcb_o[1:0],    |
// |            pcsrc_o[1:0], alucontrol_o[2:0], instret_o[CNT_W-1:0],      |
// |            illegal_o (from sequencer)                                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface mc_controller_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode_i;
   logic [5:0]       funct_i;
   logic             zero_i;
   logic             mem_ready_i;

   logic             mem_req_o;
   logic             memwrite_o;
   logic             irwrite_o;
   logic             pcen_o;
   logic             regwrite_o;
   logic             iord_o;
   logic             memtoreg_o;
   logic             regdst_o;
   logic             alusrca_o;
   logic [1:0]       alusrcb_o;
   logic [1:0]       pcsrc_o;
   logic [2:0]       alucontrol_o;
   logic [CNT_W-1:0] instret_o;
   logic             illegal_o;

   modport master (
      input  opcode_i, funct_i, zero_i, mem_ready_i,
      output mem_req_o, memwrite_o, irwrite_o, pcen_o, regwrite_o, iord_o,
             memtoreg_o, regdst_o, alusrca_o, alusrcb_o, pcsrc_o,
             alucontrol_o, instret_o, illegal_o
   );

   modport slave (
      output opcode_i, funct_i, zero_i, mem_ready_i,
      input  mem_req_o, memwrite_o, irwrite_o, pcen_o, regwrite_o, iord_o,
             memtoreg_o, regdst_o, alusrca_o, alusrcb_o, pcsrc_o,
             alucontrol_o, instret_o, illegal_o
   );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mc_controller                                               |
// | Purpose  : Moore sequencing controller for the non-pipelined multicycle|
// |            MIPS build. Shares one ALU and one unified memory port over |
// |            fetch/decode/execute/memory/writeback; memory phases are    |
// |            stretched by mem_ready_i. Decodes add/sub/and/or/slt, lw,   |
// |            sw, beq, addi and j.                                        |
// | Ports    : clk_i      - rising-edge clock                              |
// |            reset_n_i  - asynchronous active-low reset                  |
// |            bus        - mc_controller_if.master (datapath controls,    |
// |                         instruction fields, zero flag, memory ready,   |
// |                         retired-instruction count, illegal flag)       |
// | Macro    : MC_ILLEGAL_TRAP_EN - when defined, unknown opcodes lock the |
// |            controller in TRAP with a sticky illegal_o; otherwise they  |
// |            retire as NOPs and illegal_o is tied low.                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mc_controller #(
   parameter int CNT_W = 32
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   mc_controller_if.master    bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_BRANCH,
      S_ADDIEX,
      S_ADDIWB,
      S_JUMP
`ifdef MC_ILLEGAL_TRAP_EN
      , S_TRAP
`endif
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              mem_req;
   logic              memwrite;
   logic              irwrite;
   logic              pcwrite;
   logic              branch;
   logic              regwrite;
   logic              iord;
   logic              memtoreg;
   logic              regdst;
   logic              alusrca;
   logic [1:0]        alusrcb;
   logic [1:0]        pcsrc;
   logic [1:0]        aluop;
   logic [2:0]        alucontrol;
   logic              retire;      // this cycle completes an instruction
   logic [CNT_W-1:0]  instret;

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and Moore outputs
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      branch    = 1'b0;
      regwrite  = 1'b0;
      iord      = 1'b0;
      memtoreg  = 1'b0;
      regdst    = 1'b0;
      alusrca   = 1'b0;
      alusrcb   = 2'b00;
      pcsrc     = 2'b00;
      aluop     = 2'b00;
      retire    = 1'b0;

      case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            // PC+4 through the ALU; IR and PC load only on the ready cycle
            mem_req = 1'b1;
            alusrcb = 2'b01;
            irwrite = bus.mem_ready_i;
            pcwrite = bus.mem_ready_i;
            if (bus.mem_ready_i) begin
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target precomputed into ALUOut while decoding
            alusrcb = 2'b11;
            case (bus.opcode_i)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_EXEC;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_J:         state_nxt = S_JUMP;
               default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                  state_nxt = S_TRAP;
`else
                  state_nxt = S_FETCH;
                  retire    = 1'b1;
`endif
               end
            endcase
         end
         S_MEMADR: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            state_nxt = (bus.opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (bus.mem_ready_i) begin
               state_nxt = S_MEMWB;
            end
         end
         S_MEMWB: begin
            regwrite  = 1'b1;
            memtoreg  = 1'b1;
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
            if (bus.mem_ready_i) begin
               state_nxt = S_FETCH;
               retire    = 1'b1;
            end
         end
         S_EXEC: begin
            alusrca   = 1'b1;
            aluop     = 2'b10;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite  = 1'b1;
            regdst    = 1'b1;
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            alusrca   = 1'b1;
            aluop     = 2'b01;
            branch    = 1'b1;
            pcsrc     = 2'b01;
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         S_ADDIEX: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            state_nxt = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite  = 1'b1;
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         S_JUMP: begin
            pcwrite   = 1'b1;
            pcsrc     = 2'b10;
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP: begin
            // Locked until reset; every strobe stays at its default of 0
            state_nxt = S_TRAP;
         end
`endif
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ALU decoder. IDLE forces 000 so the reset state presents all-zero
   // outputs; everywhere else the aluop decode applies and never yields X.
   always_comb begin
      alucontrol = 3'b010;
      if (state == S_IDLE) begin
         alucontrol = 3'b000;
      end else begin
         case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
               case (bus.funct_i)
                  6'b100000: alucontrol = 3'b010;
                  6'b100010: alucontrol = 3'b110;
                  6'b100100: alucontrol = 3'b000;
                  6'b100101: alucontrol = 3'b001;
                  6'b101010: alucontrol = 3'b111;
                  default:   alucontrol = 3'b010;
               endcase
            end
            default: alucontrol = 3'b010;
         endcase
      end
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + CNT_W'(1);
      end
   end

`ifdef MC_ILLEGAL_TRAP_EN
   logic illegal;

   // Sticky: set on entry to TRAP so it is visible in the first TRAP cycle
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         illegal <= 1'b0;
      end else if (state_nxt == S_TRAP) begin
         illegal <= 1'b1;
      end
   end

   assign bus.illegal_o = illegal;
`else
   assign bus.illegal_o = 1'b0;
`endif

   assign bus.mem_req_o    = mem_req;
   assign bus.memwrite_o   = memwrite;
   assign bus.irwrite_o    = irwrite;
   assign bus.pcen_o       = pcwrite | (branch & bus.zero_i);
   assign bus.regwrite_o   = regwrite;
   assign bus.iord_o       = iord;
   assign bus.memtoreg_o   = memtoreg;
   assign bus.regdst_o     = regdst;
   assign bus.alusrca_o    = alusrca;
   assign bus.alusrcb_o    = alusrcb;
   assign bus.pcsrc_o      = pcsrc;
   assign bus.alucontrol_o = alucontrol;
   assign bus.instret_o    = instret;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mc_controller                                            |
// | Purpose  : Directed scoreboard bench for mc_controller. The driver     |
// |            applies one cycle of inputs and queues the hand-computed    |
// |            output word for that cycle; a negedge monitor pops and      |
// |            compares. Honours MC_ILLEGAL_TRAP_EN like the design.       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_mc_controller;

   localparam int CNT_W = 32;

   // Control word field order:
   // {mem_req, memwrite, irwrite, pcen, regwrite, iord, memtoreg, regdst,
   //  alusrca, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]}
   localparam logic [15:0] V_IDLE   = {9'b0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 3'b000};
   localparam logic [15:0] V_FWAIT  = {9'b1_0_0_0_0_0_0_0_0, 2'b01, 2'b00, 3'b010};
   localparam logic [15:0] V_FETCH  = {9'b1_0_1_1_0_0_0_0_0, 2'b01, 2'b00, 3'b010};
   localparam logic [15:0] V_DECODE = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 3'b010};
   localparam logic [15:0] V_MEMADR = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 3'b010};
   localparam logic [15:0] V_MEMRD  = {9'b1_0_0_0_0_1_0_0_0, 2'b00, 2'b00, 3'b010};
   localparam logic [15:0] V_MEMWB  = {9'b0_0_0_0_1_0_1_0_0, 2'b00, 2'b00, 3'b010};
   localparam logic [15:0] V_MEMWR  = {9'b1_1_0_0_0_1_0_0_0, 2'b00, 2'b00, 3'b010};
   localparam logic [15:0] V_ALUWB  = {9'b0_0_0_0_1_0_0_1_0, 2'b00, 2'b00, 3'b010};
   localparam logic [15:0] V_BR_T   = {9'b0_0_0_1_0_0_0_0_1, 2'b00, 2'b01, 3'b110};
   localparam logic [15:0] V_BR_NT  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 3'b110};
   localparam logic [15:0] V_ADDIEX = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 3'b010};
   localparam logic [15:0] V_ADDIWB = {9'b0_0_0_0_1_0_0_0_0, 2'b00, 2'b00, 3'b010};
   localparam logic [15:0] V_JUMP   = {9'b0_0_0_1_0_0_0_0_0, 2'b00, 2'b10, 3'b010};
`ifdef MC_ILLEGAL_TRAP_EN
   localparam logic [15:0] V_TRAP   = {9'b0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 3'b010};
`endif

   typedef struct packed {
      logic [15:0]      ctl;
      logic [CNT_W-1:0] ir;
      logic             ill;
   } exp_t;

   logic             clk;
   logic             rst_n;
   exp_t             exp_q[$];
   string            tag_q[$];
   int               n_vec;
   int               n_bad;
   logic [CNT_W-1:0] ir_exp;
   logic             ill_exp;

   mc_controller_if #(.CNT_W(CNT_W)) bus ();

   mc_controller #(.CNT_W(CNT_W)) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t actual();
      exp_t a;
      a.ctl = {bus.mem_req_o, bus.memwrite_o, bus.irwrite_o, bus.pcen_o,
               bus.regwrite_o, bus.iord_o, bus.memtoreg_o, bus.regdst_o,
               bus.alusrca_o, bus.alusrcb_o, bus.pcsrc_o, bus.alucontrol_o};
      a.ir  = bus.instret_o;
      a.ill = bus.illegal_o;
      return a;
   endfunction

   task automatic check(input string tag, input exp_t act, input exp_t exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got ctl=%h instret=%0d illegal=%b, expected ctl=%h instret=%0d illegal=%b",
                  tag, act.ctl, act.ir, act.ill, exp.ctl, exp.ir, exp.ill);
      end
   endtask

   // Monitor: every cycle with a queued expectation is compared mid-cycle
   always @(negedge clk) begin : monitor
      exp_t  e;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, actual(), e);
      end
   end

   task automatic push(input logic [15:0] ctl, input string tag);
      exp_t e;
      e.ctl = ctl;
      e.ir  = ir_exp;
      e.ill = ill_exp;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // One clock cycle of the current inputs, expecting ctl throughout
   task automatic cyc(input logic [15:0] ctl, input string tag);
      push(ctl, tag);
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      cyc(V_IDLE, "idle");
   endtask

   initial begin
      logic [5:0] fn_tab [5];
      logic [2:0] ac_tab [5];
      exp_t       e_rst;
      fn_tab = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
      ac_tab = '{3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

      n_vec           = 0;
      n_bad           = 0;
      ir_exp          = '0;
      ill_exp         = 1'b0;
      rst_n           = 1'b0;
      bus.opcode_i    = 6'b000000;
      bus.funct_i     = 6'b100000;
      bus.zero_i      = 1'b0;
      bus.mem_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // R-type add, zero wait states
      release_reset();
      cyc(V_FETCH, "add_fetch");
      cyc(V_DECODE, "add_decode");
      cyc({9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 3'b010}, "add_exec");
      cyc(V_ALUWB, "add_aluwb");
      ir_exp++;

      // Remaining R-type functs plus an unlisted funct
      for (int i = 0; i < 5; i++) begin
         bus.funct_i = fn_tab[i];
         cyc(V_FETCH, "r_fetch");
         cyc(V_DECODE, "r_decode");
         cyc({9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, ac_tab[i]}, "r_exec_aluc");
         cyc(V_ALUWB, "r_aluwb");
         ir_exp++;
      end

      // lw: 2 wait cycles in FETCH, 3 in MEMRD -> 10 cycles
      bus.opcode_i    = 6'b100011;
      bus.funct_i     = 6'b000000;
      bus.mem_ready_i = 1'b0;
      cyc(V_FWAIT, "lw_fetch_wait");
      cyc(V_FWAIT, "lw_fetch_wait");
      bus.mem_ready_i = 1'b1;
      cyc(V_FETCH, "lw_fetch");
      cyc(V_DECODE, "lw_decode");
      cyc(V_MEMADR, "lw_memadr");
      bus.mem_ready_i = 1'b0;
      repeat (3) cyc(V_MEMRD, "lw_memrd_wait");
      bus.mem_ready_i = 1'b1;
      cyc(V_MEMRD, "lw_memrd");
      cyc(V_MEMWB, "lw_memwb");
      ir_exp++;

      // beq taken then not taken
      bus.opcode_i = 6'b000100;
      cyc(V_FETCH, "beq1_fetch");
      cyc(V_DECODE, "beq1_decode");
      bus.zero_i = 1'b1;
      cyc(V_BR_T, "beq_taken");
      ir_exp++;
      cyc(V_FETCH, "beq2_fetch");
      cyc(V_DECODE, "beq2_decode");
      bus.zero_i = 1'b0;
      cyc(V_BR_NT, "beq_not_taken");
      ir_exp++;

      // sw, ready on the second MEMWR cycle
      bus.opcode_i = 6'b101011;
      cyc(V_FETCH, "sw_fetch");
      cyc(V_DECODE, "sw_decode");
      cyc(V_MEMADR, "sw_memadr");
      bus.mem_ready_i = 1'b0;
      cyc(V_MEMWR, "sw_memwr_wait");
      bus.mem_ready_i = 1'b1;
      cyc(V_MEMWR, "sw_memwr");
      ir_exp++;

      // Unknown opcode
      bus.opcode_i = 6'b111111;
      cyc(V_FETCH, "ill_fetch");
      cyc(V_DECODE, "ill_decode");
`ifdef MC_ILLEGAL_TRAP_EN
      ill_exp = 1'b1;
      repeat (3) cyc(V_TRAP, "trap_hold");
      rst_n   = 1'b0;
      ir_exp  = '0;
      ill_exp = 1'b0;
      @(posedge clk);
      #1;
      release_reset();
`else
      ir_exp++;
`endif

      // addi with an asynchronous reset in the middle of ADDIWB
      bus.opcode_i = 6'b001000;
      cyc(V_FETCH, "addi_fetch");
      cyc(V_DECODE, "addi_decode");
      cyc(V_ADDIEX, "addi_ex");
      push(V_ADDIWB, "addi_wb");
      @(negedge clk);
      #1;
      rst_n  = 1'b0;
      ir_exp = '0;
      #1;
      e_rst.ctl = V_IDLE;
      e_rst.ir  = '0;
      e_rst.ill = 1'b0;
      check("rst_async", actual(), e_rst);
      @(posedge clk);
      #1;
      release_reset();

      // j after reset
      bus.opcode_i = 6'b000010;
      cyc(V_FETCH, "j_fetch");
      cyc(V_DECODE, "j_decode");
      cyc(V_JUMP, "j_jump");
      ir_exp++;
      cyc(V_FETCH, "post_j_fetch");

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench still running at %0t, required finish", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
